// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
//   Shared definitions for the memory stage:
//     `MMOP_W / `MMOP : width and range of the one-hot memory-op vector
//     MOP_*           : bit index of each memory op inside that vector
//     LOAD_MASK       : which memory ops return data to the register file
//     mem_state_e     : 3-bit encoding of the bus-transaction FSM
//     is_load_op()    : true when the one-hot op is any kind of load
// ---------------------------------------------------------------------------
`ifndef MEM_ACCESS_DEFS_SVH
`define MEM_ACCESS_DEFS_SVH
`define MMOP_W 12
`define MMOP `MMOP_W-1:0
`endif

package mem_access_pkg;

  localparam int MOP_LB  = 0;
  localparam int MOP_LBU = 1;
  localparam int MOP_LH  = 2;
  localparam int MOP_LHU = 3;
  localparam int MOP_LW  = 4;
  localparam int MOP_SB  = 5;
  localparam int MOP_SH  = 6;
  localparam int MOP_SW  = 7;
  localparam int MOP_LWL = 8;
  localparam int MOP_LWR = 9;
  localparam int MOP_SWL = 10;
  localparam int MOP_SWR = 11;

  // lb, lbu, lh, lhu, lw, lwl, lwr
  localparam logic [`MMOP] LOAD_MASK = 12'b0011_0001_1111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT      = 3'd2,
    ST_HOLD      = 3'd3,
    ST_DRAIN_REQ = 3'd4,
    ST_DRAIN     = 3'd5
  } mem_state_e;

  function automatic logic is_load_op(input logic [`MMOP] memop);
    return |(memop & LOAD_MASK);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// ---------------------------------------------------------------------------
// mem_load_align
//   Purely combinational load extractor / merger (little-endian).
//   Ports:
//     memop_i    one-hot memory op
//     addr_low_i byte offset within the word
//     rdata_i    raw word returned by the data bus
//     rtvalue_i  current rt value, merged in for lwl/lwr
//     wdata_o    value to be written to the register file
//   Non-load ops pass rdata_i through; the caller ignores it in that case.
// ---------------------------------------------------------------------------
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [`MMOP] memop_i,
  input  logic [1:0]   addr_low_i,
  input  logic [31:0]  rdata_i,
  input  logic [31:0]  rtvalue_i,
  output logic [31:0]  wdata_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        unused_store_ops;

  // Store ops never reach the register file through this path.
  assign unused_store_ops = ^{memop_i[MOP_SB], memop_i[MOP_SH], memop_i[MOP_SW],
                              memop_i[MOP_SWL], memop_i[MOP_SWR]};

  // Byte lane picked by the offset; half lane picked by offset bit 1.
  always_comb begin
    case (addr_low_i)
      2'd0:    sel_byte = rdata_i[7:0];
      2'd1:    sel_byte = rdata_i[15:8];
      2'd2:    sel_byte = rdata_i[23:16];
      default: sel_byte = rdata_i[31:24];
    endcase
    sel_half = addr_low_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // lwl fills the register from its top down; lwr from its bottom up.
  always_comb begin
    wdata_o = rdata_i;
    if (memop_i[MOP_LB]) begin
      wdata_o = {{24{sel_byte[7]}}, sel_byte};
    end else if (memop_i[MOP_LBU]) begin
      wdata_o = {24'd0, sel_byte};
    end else if (memop_i[MOP_LH]) begin
      wdata_o = {{16{sel_half[15]}}, sel_half};
    end else if (memop_i[MOP_LHU]) begin
      wdata_o = {16'd0, sel_half};
    end else if (memop_i[MOP_LW]) begin
      wdata_o = rdata_i;
    end else if (memop_i[MOP_LWL]) begin
      case (addr_low_i)
        2'd0:    wdata_o = {rdata_i[7:0],  rtvalue_i[23:0]};
        2'd1:    wdata_o = {rdata_i[15:0], rtvalue_i[15:0]};
        2'd2:    wdata_o = {rdata_i[23:0], rtvalue_i[7:0]};
        default: wdata_o = rdata_i;
      endcase
    end else if (memop_i[MOP_LWR]) begin
      case (addr_low_i)
        2'd0:    wdata_o = rdata_i;
        2'd1:    wdata_o = {rtvalue_i[31:24], rdata_i[31:8]};
        2'd2:    wdata_o = {rtvalue_i[31:16], rdata_i[31:16]};
        default: wdata_o = {rtvalue_i[31:8],  rdata_i[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
//   Memory pipeline stage. Issues one data-bus transaction at a time over a
//   req/addr_ok/data_ok handshake, aligns load data, stalls the pipeline
//   until the access completes, registers the result toward writeback and
//   silently drains responses belonging to flushed instructions.
//
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     mem_*_i             instruction currently in MEM (from EX register)
//     data_*_o / data_*_i data-bus master side
//     mem_wren_o .. pc_o  registered result toward WB
//     mem_stallreq_o      stall request to the pipeline controller
//     mem_wdata_bp_o      bypass value (value about to be registered)
//     mem_nofwd_bp_o      bypass value not yet valid (load still pending)
//     mem_stall_cnt_o     stall-cycle counter
//
//   Optional feature macro: MEM_STALL_CNT_EN
//     defined   -> mem_stall_cnt_o counts cycles with mem_stallreq_o high,
//                  saturating at all-ones
//     undefined -> mem_stall_cnt_o is tied to zero
// ---------------------------------------------------------------------------
module mem_access
  import mem_access_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_flush_i,
  input  logic                   mem_stall_i,
  input  logic                   mem_memen_i,
  input  logic                   mem_has_exc_i,
  input  logic [`MMOP]           mem_memop_i,
  input  logic [3:0]             mem_memwen_i,
  input  logic [31:0]            mem_memaddr_i,
  input  logic [1:0]             mem_memaddr_low_i,
  input  logic [31:0]            mem_memwdata_i,
  input  logic [31:0]            mem_rtvalue_i,
  input  logic [3:0]             mem_wren_i,
  input  logic [4:0]             mem_waddr_i,
  input  logic [31:0]            mem_wdata_i,
  input  logic [31:0]            mem_pc_i,
  output logic                   data_req_o,
  output logic                   data_wr_o,
  output logic [3:0]             data_wstrb_o,
  output logic [31:0]            data_addr_o,
  output logic [31:0]            data_wdata_o,
  input  logic                   data_addr_ok_i,
  input  logic                   data_data_ok_i,
  input  logic [31:0]            data_rdata_i,
  output logic [3:0]             mem_wren_o,
  output logic [4:0]             mem_waddr_o,
  output logic [31:0]            mem_wdata_o,
  output logic [31:0]            mem_pc_o,
  output logic                   mem_stallreq_o,
  output logic [31:0]            mem_wdata_bp_o,
  output logic                   mem_nofwd_bp_o,
  output logic [STALL_CNT_W-1:0] mem_stall_cnt_o
);

  mem_state_e  state_q, state_d;

  logic        access;
  logic        load_access;
  logic        data_avail;
  logic        buf_load;

  logic [31:0] lat_addr_q;
  logic [31:0] lat_wdata_q;
  logic [3:0]  lat_wstrb_q;
  logic        lat_wr_q;

  logic [31:0] rbuf_q;
  logic [31:0] load_src;
  logic [31:0] load_val;
  logic [31:0] wdata_next;

  assign access      = mem_memen_i & ~mem_has_exc_i & ~mem_flush_i;
  assign load_access = access & is_load_op(mem_memop_i);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus stall request. A flush that lands after the bus
  // has accepted a request cannot cancel it, so the FSM walks through the
  // DRAIN states and throws the orphaned response away before anything new
  // is issued. A flush together with addr_ok in REQ means the request was
  // just accepted, hence straight to DRAIN.
  always_comb begin
    state_d        = state_q;
    buf_load       = 1'b0;
    data_avail     = 1'b0;
    mem_stallreq_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_stallreq_o = access;
        if (access) begin
          state_d = data_addr_ok_i ? ST_WAIT : ST_REQ;
        end
      end
      ST_REQ: begin
        mem_stallreq_o = 1'b1;
        if (data_addr_ok_i) begin
          state_d = mem_flush_i ? ST_DRAIN : ST_WAIT;
        end else if (mem_flush_i) begin
          state_d = ST_DRAIN_REQ;
        end
      end
      ST_WAIT: begin
        mem_stallreq_o = ~data_data_ok_i;
        data_avail     = data_data_ok_i;
        if (mem_flush_i) begin
          state_d = data_data_ok_i ? ST_IDLE : ST_DRAIN;
        end else if (data_data_ok_i) begin
          if (mem_stall_i) begin
            state_d  = ST_HOLD;
            buf_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        data_avail = 1'b1;
        if (mem_flush_i || !mem_stall_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN_REQ: begin
        mem_stallreq_o = access;
        if (data_addr_ok_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        mem_stallreq_o = access;
        if (data_data_ok_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus drive. In IDLE the request goes out straight from the stage inputs
  // so an access can be accepted in its first cycle; afterwards the latched
  // copy keeps the address stable even if the upstream inputs wiggle.
  always_comb begin
    data_req_o   = 1'b0;
    data_wr_o    = lat_wr_q;
    data_wstrb_o = lat_wstrb_q;
    data_addr_o  = lat_addr_q;
    data_wdata_o = lat_wdata_q;
    case (state_q)
      ST_IDLE: begin
        data_req_o   = access;
        data_wr_o    = |mem_memwen_i;
        data_wstrb_o = mem_memwen_i;
        data_addr_o  = mem_memaddr_i;
        data_wdata_o = mem_memwdata_i;
      end
      ST_REQ, ST_DRAIN_REQ: data_req_o = 1'b1;
      default: data_req_o = 1'b0;
    endcase
  end

  // Request latch, refreshed whenever a request is presented from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_wstrb_q <= '0;
      lat_wr_q    <= 1'b0;
    end else if (state_q == ST_IDLE && access) begin
      lat_addr_q  <= mem_memaddr_i;
      lat_wdata_q <= mem_memwdata_i;
      lat_wstrb_q <= mem_memwen_i;
      lat_wr_q    <= |mem_memwen_i;
    end
  end

  // Read-data buffer for a response that arrives while the pipeline is
  // stalled downstream; the bus will not present it again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbuf_q <= '0;
    end else if (buf_load) begin
      rbuf_q <= data_rdata_i;
    end
  end

  assign load_src = (state_q == ST_HOLD) ? rbuf_q : data_rdata_i;

  mem_load_align u_align (
    .memop_i    (mem_memop_i),
    .addr_low_i (mem_memaddr_low_i),
    .rdata_i    (load_src),
    .rtvalue_i  (mem_rtvalue_i),
    .wdata_o    (load_val)
  );

  assign wdata_next     = load_access ? load_val : mem_wdata_i;
  assign mem_wdata_bp_o = wdata_next;
  assign mem_nofwd_bp_o = load_access & ~data_avail;

  // Result register toward WB. Flush has priority and empties the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wren_o  <= '0;
      mem_waddr_o <= '0;
      mem_wdata_o <= '0;
      mem_pc_o    <= '0;
    end else if (mem_flush_i) begin
      mem_wren_o  <= '0;
      mem_waddr_o <= '0;
      mem_wdata_o <= '0;
      mem_pc_o    <= '0;
    end else if (!mem_stall_i && !mem_stallreq_o) begin
      mem_wren_o  <= mem_wren_i;
      mem_waddr_o <= mem_waddr_i;
      mem_wdata_o <= wdata_next;
      mem_pc_o    <= mem_pc_i;
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles in which this stage asked for a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (mem_stallreq_o && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign mem_stall_cnt_o = stall_cnt_q;
`else
  assign mem_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
//   Directed bench for mem_access. The bench plays the bus slave by hand,
//   cycle by cycle, and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_flush_i = 1'b0;
  logic        mem_stall_i = 1'b0;
  logic        mem_memen_i = 1'b0;
  logic        mem_has_exc_i = 1'b0;
  logic [11:0] mem_memop_i = '0;
  logic [3:0]  mem_memwen_i = '0;
  logic [31:0] mem_memaddr_i = '0;
  logic [1:0]  mem_memaddr_low_i = '0;
  logic [31:0] mem_memwdata_i = '0;
  logic [31:0] mem_rtvalue_i = '0;
  logic [3:0]  mem_wren_i = '0;
  logic [4:0]  mem_waddr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_pc_i = '0;
  logic        data_req_o;
  logic        data_wr_o;
  logic [3:0]  data_wstrb_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_addr_ok_i = 1'b0;
  logic        data_data_ok_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic [3:0]  mem_wren_o;
  logic [4:0]  mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_pc_o;
  logic        mem_stallreq_o;
  logic [31:0] mem_wdata_bp_o;
  logic        mem_nofwd_bp_o;
  logic [31:0] mem_stall_cnt_o;

  int total = 0;
  int bad   = 0;

  localparam logic [11:0] OP_LB  = 12'h001;
  localparam logic [11:0] OP_LBU = 12'h002;
  localparam logic [11:0] OP_LH  = 12'h004;
  localparam logic [11:0] OP_LHU = 12'h008;
  localparam logic [11:0] OP_LW  = 12'h010;
  localparam logic [11:0] OP_SW  = 12'h080;
  localparam logic [11:0] OP_LWL = 12'h100;
  localparam logic [11:0] OP_LWR = 12'h200;

  mem_access #(.STALL_CNT_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_flush_i       (mem_flush_i),
    .mem_stall_i       (mem_stall_i),
    .mem_memen_i       (mem_memen_i),
    .mem_has_exc_i     (mem_has_exc_i),
    .mem_memop_i       (mem_memop_i),
    .mem_memwen_i      (mem_memwen_i),
    .mem_memaddr_i     (mem_memaddr_i),
    .mem_memaddr_low_i (mem_memaddr_low_i),
    .mem_memwdata_i    (mem_memwdata_i),
    .mem_rtvalue_i     (mem_rtvalue_i),
    .mem_wren_i        (mem_wren_i),
    .mem_waddr_i       (mem_waddr_i),
    .mem_wdata_i       (mem_wdata_i),
    .mem_pc_i          (mem_pc_i),
    .data_req_o        (data_req_o),
    .data_wr_o         (data_wr_o),
    .data_wstrb_o      (data_wstrb_o),
    .data_addr_o       (data_addr_o),
    .data_wdata_o      (data_wdata_o),
    .data_addr_ok_i    (data_addr_ok_i),
    .data_data_ok_i    (data_data_ok_i),
    .data_rdata_i      (data_rdata_i),
    .mem_wren_o        (mem_wren_o),
    .mem_waddr_o       (mem_waddr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_pc_o          (mem_pc_o),
    .mem_stallreq_o    (mem_stallreq_o),
    .mem_wdata_bp_o    (mem_wdata_bp_o),
    .mem_nofwd_bp_o    (mem_nofwd_bp_o),
    .mem_stall_cnt_o   (mem_stall_cnt_o)
  );

  always #5 clk = ~clk;

  // One comparison: count it, report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction to the MEM stage.
  task automatic applyStimulus(input logic [11:0] op, input logic [3:0] wen,
                               input logic [31:0] addr, input logic [1:0] low,
                               input logic [31:0] st_data, input logic [31:0] rt,
                               input logic [3:0] wren, input logic [4:0] waddr,
                               input logic [31:0] wd, input logic [31:0] pc);
    mem_memen_i       = (op != 12'd0);
    mem_memop_i       = op;
    mem_memwen_i      = wen;
    mem_memaddr_i     = addr;
    mem_memaddr_low_i = low;
    mem_memwdata_i    = st_data;
    mem_rtvalue_i     = rt;
    mem_wren_i        = wren;
    mem_waddr_i       = waddr;
    mem_wdata_i       = wd;
    mem_pc_i          = pc;
  endtask

  task automatic applyNop();
    applyStimulus(12'd0, 4'd0, 32'd0, 2'd0, 32'd0, 32'd0, 4'd0, 5'd0, 32'd0, 32'd0);
  endtask

  // Load accepted in its first cycle, data the cycle after: one stall cycle.
  task automatic runLoad(input string tag, input logic [11:0] op, input logic [1:0] low,
                         input logic [31:0] rt, input logic [31:0] rdata,
                         input logic [31:0] expv);
    applyStimulus(op, 4'd0, 32'h0000_0100, low, 32'd0, rt, 4'hF, 5'd5, 32'h0, 32'h0000_0400);
    data_addr_ok_i = 1'b1;
    #1;
    checkOutput({tag, ".req"}, data_req_o, 1);
    checkOutput({tag, ".stall1"}, mem_stallreq_o, 1);
    checkOutput({tag, ".nofwd1"}, mem_nofwd_bp_o, 1);
    tick();
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    data_rdata_i   = rdata;
    #1;
    checkOutput({tag, ".stall2"}, mem_stallreq_o, 0);
    checkOutput({tag, ".bp"}, mem_wdata_bp_o, expv);
    tick();
    data_data_ok_i = 1'b0;
    applyNop();
    checkOutput({tag, ".wdata"}, mem_wdata_o, expv);
    checkOutput({tag, ".waddr"}, mem_waddr_o, 5);
  endtask

  initial begin
    applyNop();
    repeat (2) tick();
    checkOutput("rst.wdata", mem_wdata_o, 0);
    checkOutput("rst.wren", mem_wren_o, 0);
    checkOutput("rst.pc", mem_pc_o, 0);
    checkOutput("rst.req", data_req_o, 0);
    checkOutput("rst.stallreq", mem_stallreq_o, 0);
    rst = 1'b0;
    tick();

    // Load alignment table.
    runLoad("lb3",  OP_LB,  2'd3, 32'h0, 32'h80AA_5511, 32'hFFFF_FF80);
    runLoad("lbu3", OP_LBU, 2'd3, 32'h0, 32'h80AA_5511, 32'h0000_0080);
    runLoad("lh2",  OP_LH,  2'd2, 32'h0, 32'h80AA_5511, 32'hFFFF_80AA);
    runLoad("lhu0", OP_LHU, 2'd0, 32'h0, 32'h80AA_5511, 32'h0000_5511);
    runLoad("lw",   OP_LW,  2'd0, 32'h0, 32'h80AA_5511, 32'h80AA_5511);
    runLoad("lwl1", OP_LWL, 2'd1, 32'hAABB_CCDD, 32'h4433_2211, 32'h2211_CCDD);
    runLoad("lwl0", OP_LWL, 2'd0, 32'hAABB_CCDD, 32'h4433_2211, 32'h11BB_CCDD);
    runLoad("lwr2", OP_LWR, 2'd2, 32'hAABB_CCDD, 32'h4433_2211, 32'hAABB_4433);
    runLoad("lwr3", OP_LWR, 2'd3, 32'hAABB_CCDD, 32'h4433_2211, 32'hAABB_CC44);

    // addr_ok held off for three cycles; upstream address changes meanwhile.
    applyStimulus(OP_LW, 4'd0, 32'h0000_0200, 2'd0, 32'd0, 32'd0, 4'hF, 5'd6, 32'd0, 32'h0000_0500);
    #1;
    checkOutput("dly.req0", data_req_o, 1);
    checkOutput("dly.addr0", data_addr_o, 32'h0000_0200);
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_memaddr_i = 32'h0000_BAD0;
      if (i == 2) data_addr_ok_i = 1'b1;
      #1;
      checkOutput("dly.req", data_req_o, 1);
      checkOutput("dly.addr", data_addr_o, 32'h0000_0200);
      checkOutput("dly.stallreq", mem_stallreq_o, 1);
    end
    tick();
    data_addr_ok_i = 1'b0;
    #1;
    checkOutput("dly.waitreq", data_req_o, 0);
    checkOutput("dly.waitstall", mem_stallreq_o, 1);
    tick();
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h1234_5678;
    #1;
    checkOutput("dly.donestall", mem_stallreq_o, 0);
    tick();
    data_data_ok_i = 1'b0;
    applyNop();
    checkOutput("dly.wdata", mem_wdata_o, 32'h1234_5678);
    checkOutput("dly.waddr", mem_waddr_o, 6);
    tick();

    // Flush in WAIT, then a new load must wait for the orphan to drain.
    applyStimulus(OP_LW, 4'd0, 32'h0000_0300, 2'd0, 32'd0, 32'd0, 4'hF, 5'd3, 32'd0, 32'h0000_0600);
    data_addr_ok_i = 1'b1;
    tick();
    data_addr_ok_i = 1'b0;
    mem_flush_i    = 1'b1;
    tick();
    mem_flush_i = 1'b0;
    checkOutput("fl.wren", mem_wren_o, 0);
    applyStimulus(OP_LW, 4'd0, 32'h0000_0340, 2'd0, 32'd0, 32'd0, 4'hF, 5'd7, 32'd0, 32'h0000_0604);
    data_addr_ok_i = 1'b1;
    #1;
    checkOutput("fl.noreq1", data_req_o, 0);
    checkOutput("fl.stall1", mem_stallreq_o, 1);
    tick();
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'hDEAD_BEEF;
    #1;
    checkOutput("fl.noreq2", data_req_o, 0);
    checkOutput("fl.stall2", mem_stallreq_o, 1);
    tick();
    data_data_ok_i = 1'b0;
    #1;
    checkOutput("fl.newreq", data_req_o, 1);
    checkOutput("fl.newaddr", data_addr_o, 32'h0000_0340);
    tick();
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'hCAFE_F00D;
    tick();
    data_data_ok_i = 1'b0;
    applyNop();
    checkOutput("fl.wdata", mem_wdata_o, 32'hCAFE_F00D);
    checkOutput("fl.waddr", mem_waddr_o, 7);
    tick();
    checkOutput("nop.wdata", mem_wdata_o, 0);

    // Response arrives while downstream is stalled.
    applyStimulus(OP_LW, 4'd0, 32'h0000_0400, 2'd0, 32'd0, 32'd0, 4'hF, 5'd9, 32'd0, 32'h0000_0700);
    data_addr_ok_i = 1'b1;
    tick();
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h0BAD_CAFE;
    mem_stall_i    = 1'b1;
    #1;
    checkOutput("hold.stallreq0", mem_stallreq_o, 0);
    tick();
    data_data_ok_i = 1'b0;
    data_rdata_i   = 32'h0;
    #1;
    checkOutput("hold.stallreq1", mem_stallreq_o, 0);
    checkOutput("hold.bp", mem_wdata_bp_o, 32'h0BAD_CAFE);
    checkOutput("hold.kept", mem_wdata_o, 0);
    tick();
    mem_stall_i = 1'b0;
    checkOutput("hold.kept2", mem_wdata_o, 0);
    tick();
    applyNop();
    checkOutput("hold.wdata", mem_wdata_o, 32'h0BAD_CAFE);
    checkOutput("hold.pc", mem_pc_o, 32'h0000_0700);
    tick();

    // Store with an exception makes no access and just passes through.
    applyStimulus(OP_SW, 4'hF, 32'h0000_0500, 2'd0, 32'h1122_3344, 32'd0, 4'd0, 5'd0, 32'h55, 32'h0000_0800);
    mem_has_exc_i  = 1'b1;
    data_addr_ok_i = 1'b1;
    #1;
    checkOutput("exc.req", data_req_o, 0);
    checkOutput("exc.stallreq", mem_stallreq_o, 0);
    tick();
    mem_has_exc_i = 1'b0;
    checkOutput("exc.wren", mem_wren_o, 0);
    checkOutput("exc.wdata", mem_wdata_o, 32'h55);

    // Normal store: write fields on the bus, commit only after data_ok.
    #1;
    checkOutput("sw.req", data_req_o, 1);
    checkOutput("sw.wr", data_wr_o, 1);
    checkOutput("sw.wstrb", data_wstrb_o, 4'hF);
    checkOutput("sw.wdata", data_wdata_o, 32'h1122_3344);
    tick();
    data_addr_ok_i = 1'b0;
    #1;
    checkOutput("sw.waitstall", mem_stallreq_o, 1);
    checkOutput("sw.notyet", mem_pc_o, 32'h0000_0800);
    tick();
    data_data_ok_i = 1'b1;
    tick();
    data_data_ok_i = 1'b0;
    applyNop();
    checkOutput("sw.pc", mem_pc_o, 32'h0000_0800);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
